// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: core/host arbiter and access sequencer for the shared DATA_MEM.
// Define DATA_MEM_ARB_RR_EN for round-robin arbitration instead of fixed host priority.
module data_mem_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [ADDR_SIZE-1:0] core_addr,
    input  logic [DATA_SIZE-1:0] core_wdata,
    output logic                 core_gnt,
    output logic                 core_rvalid,
    output logic [DATA_SIZE-1:0] core_rdata,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [DATA_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [DATA_SIZE-1:0] host_rdata,
    output logic                 mem_w,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [2:0] LAT     = 3'(RD_LAT);

    logic [1:0]           r_state;
    logic                 r_owner;
    logic                 r_we;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [DATA_SIZE-1:0] r_wdata;
    logic [2:0]           r_cnt;
    logic                 r_core_rvalid;
    logic                 r_host_rvalid;
    logic [DATA_SIZE-1:0] r_core_rdata;
    logic [DATA_SIZE-1:0] r_host_rdata;
    logic                 w_any_req;
    logic                 w_pick_host;

    assign w_any_req = core_req | host_req;

`ifdef DATA_MEM_ARB_RR_EN
    // r_last_host = 1 means the host owned the most recent ISSUE
    logic r_last_host;

    always_comb begin
        w_pick_host = host_req && (!core_req || !r_last_host);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_host <= 1'b1;
        end else if (r_state == S_ISSUE) begin
            r_last_host <= r_owner;
        end
    end
`else
    always_comb begin
        w_pick_host = host_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_core_rvalid <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_core_rdata  <= '0;
            r_host_rdata  <= '0;
        end else begin
            r_core_rvalid <= 1'b0;
            r_host_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick_host;
                        r_we    <= w_pick_host ? host_we : core_we;
                        r_addr  <= w_pick_host ? host_addr : core_addr;
                        r_wdata <= w_pick_host ? host_wdata : core_wdata;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= LAT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // last wait cycle: memory data is valid now
                    if (r_cnt == 3'd1) begin
                        if (r_owner) begin
                            r_host_rdata  <= mem_rdata;
                            r_host_rvalid <= 1'b1;
                        end else begin
                            r_core_rdata  <= mem_rdata;
                            r_core_rvalid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_gnt    = (r_state == S_ISSUE) && !r_owner;
    assign host_gnt    = (r_state == S_ISSUE) && r_owner;
    assign core_rvalid = r_core_rvalid;
    assign host_rvalid = r_host_rvalid;
    assign core_rdata  = r_core_rdata;
    assign host_rdata  = r_host_rdata;
    assign mem_w       = (r_state == S_ISSUE) && r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: vector table plus hand sequences for data_mem_arbiter.
// Follows DATA_MEM_ARB_RR_EN for the contention expectations.
module tb_data_mem_arbiter;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       core_req, core_we, host_req, host_we;
    logic [3:0] core_addr, host_addr;
    logic [7:0] core_wdata, host_wdata;
    logic       core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic [7:0] core_rdata, host_rdata;
    logic       mem_w;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .DATA_SIZE(8),
        .ADDR_SIZE(4),
        .RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // memory with LAT cycles from address to data
    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] pipe [LAT] = '{default: 8'h00};

    always @(posedge clk) begin
        if (mem_w) mem[mem_addr] <= mem_wdata;
        pipe[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    typedef struct {
        logic       host;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [7:0] act);
        logic [7:0] e;
        e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        chk(name, {24'h0, act}, {24'h0, e});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic do_access(input vec_t v);
        int n;
        int wcnt;
        int ocnt;
        logic g;
        logic [7:0] other;
        if (v.host) begin
            host_req = 1'b1; host_we = v.we;
            host_addr = v.addr; host_wdata = v.wdata;
        end else begin
            core_req = 1'b1; core_we = v.we;
            core_addr = v.addr; core_wdata = v.wdata;
        end
        other = v.host ? core_rdata : host_rdata;
        n = 0;
        g = 1'b0;
        while (!g && n < 8) begin
            cyc();
            n++;
            g = v.host ? host_gnt : core_gnt;
        end
        chk("gnt_lat", n, 1);
        chk("mem_w", {31'h0, mem_w}, {31'h0, v.we});
        chk("mem_addr", {28'h0, mem_addr}, {28'h0, v.addr});
        if (v.we) chk("mem_wdata", {24'h0, mem_wdata}, {24'h0, v.wdata});
        chk("other_gnt", {31'h0, v.host ? core_gnt : host_gnt}, 0);
        host_req = 1'b0;
        core_req = 1'b0;
        if (v.we) begin
            cyc();
            chk("busy_after_wr", {31'h0, busy}, 0);
        end else begin
            sb.push_back(v.exp_rd);
            n = 1;
            g = 1'b0;
            wcnt = 0;
            ocnt = 0;
            while (!g && n < LAT + 6) begin
                cyc();
                n++;
                g = v.host ? host_rvalid : core_rvalid;
                if (mem_w) wcnt++;
                if (v.host ? core_rvalid : host_rvalid) ocnt++;
            end
            chk("rv_lat", n, 2 + LAT);
            sb_check("rdata", v.host ? host_rdata : core_rdata);
            chk("busy_at_rv", {31'h0, busy}, 0);
            chk("mem_w_in_wait", wcnt, 0);
            chk("other_rvalid", ocnt, 0);
            chk("other_rdata", {24'h0, v.host ? core_rdata : host_rdata},
                {24'h0, other});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int n, gn, rn, rv;
        logic g;
        logic exp_host;
        vec_t wv;

        vecs[0] = '{host: 1'b0, we: 1'b1, addr: 4'h3, wdata: 8'hA5, exp_rd: 8'h00};
        vecs[1] = '{host: 1'b1, we: 1'b0, addr: 4'h3, wdata: 8'h00, exp_rd: 8'hA5};
        vecs[2] = '{host: 1'b0, we: 1'b1, addr: 4'h1, wdata: 8'h11, exp_rd: 8'h00};
        vecs[3] = '{host: 1'b1, we: 1'b1, addr: 4'h2, wdata: 8'h22, exp_rd: 8'h00};
        vecs[4] = '{host: 1'b0, we: 1'b0, addr: 4'h2, wdata: 8'h00, exp_rd: 8'h22};
        vecs[5] = '{host: 1'b1, we: 1'b0, addr: 4'h1, wdata: 8'h00, exp_rd: 8'h11};
        vecs[6] = '{host: 1'b1, we: 1'b1, addr: 4'h3, wdata: 8'h5A, exp_rd: 8'h00};
        vecs[7] = '{host: 1'b0, we: 1'b0, addr: 4'h3, wdata: 8'h00, exp_rd: 8'h5A};
        vecs[8] = '{host: 1'b0, we: 1'b0, addr: 4'hF, wdata: 8'h00, exp_rd: 8'h00};

        rst = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_ctrl", {26'h0, core_gnt, host_gnt, core_rvalid, host_rvalid,
            mem_w, busy}, 0);
        chk("rst_data", {4'h0, mem_addr, mem_wdata, core_rdata, host_rdata}, 0);

        for (int i = 0; i < 9; i++) do_access(vecs[i]);

        // both requesters hold write requests continuously
        do_reset();
        core_req = 1'b1; core_we = 1'b1; core_addr = 4'h5; core_wdata = 8'h55;
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'h6; host_wdata = 8'h66;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            g = 1'b0;
            while (!g && n < 4) begin
                cyc();
                n++;
                g = core_gnt | host_gnt;
            end
`ifdef DATA_MEM_ARB_RR_EN
            exp_host = k[0];
`else
            exp_host = 1'b1;
`endif
            chk("arb_gap", n, k == 0 ? 1 : 2);
            chk("arb_host_gnt", {31'h0, host_gnt}, {31'h0, exp_host});
            chk("arb_core_gnt", {31'h0, core_gnt}, {31'h0, !exp_host});
        end
        core_req = 1'b0;
        host_req = 1'b0;
        cyc();

        // back-to-back core reads, second request held through first rvalid
        core_req = 1'b1; core_we = 1'b0; core_addr = 4'h1;
        sb.push_back(8'h11);
        gn = 0;
        rn = 0;
        for (int c = 1; c <= 5 + 2 * LAT; c++) begin
            cyc();
            chk("b2b_excl", {31'h0, core_gnt & core_rvalid}, 0);
            if (core_gnt) begin
                gn++;
                if (gn == 1) begin
                    chk("b2b_gnt1", c, 1);
                    core_addr = 4'h2;
                    sb.push_back(8'h22);
                end else begin
                    chk("b2b_gnt2", c, 3 + LAT);
                    core_req = 1'b0;
                end
            end
            if (core_rvalid) begin
                rn++;
                chk("b2b_rv_cyc", c, rn == 1 ? 2 + LAT : 4 + 2 * LAT);
                sb_check("b2b_rdata", core_rdata);
            end
        end
        core_req = 1'b0;
        chk("b2b_gnt_cnt", gn, 2);
        chk("b2b_rv_cnt", rn, 2);

        // reset during WAIT of a host read aborts it
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'h3;
        cyc();
        chk("abort_gnt", {31'h0, host_gnt}, 1);
        host_req = 1'b0;
        cyc();
        chk("abort_wait_busy", {31'h0, busy}, 1);
        rst = 1'b1;
        cyc();
        chk("abort_ctrl", {26'h0, core_gnt, host_gnt, core_rvalid, host_rvalid,
            mem_w, busy}, 0);
        chk("abort_data", {4'h0, mem_addr, mem_wdata, core_rdata, host_rdata}, 0);
        rst = 1'b0;
        rv = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (host_rvalid | host_gnt | mem_w | busy) rv++;
        end
        chk("abort_quiet", rv, 0);
        wv = '{host: 1'b0, we: 1'b1, addr: 4'h7, wdata: 8'h77, exp_rd: 8'h00};
        do_access(wv);
        wv = '{host: 1'b0, we: 1'b0, addr: 4'h7, wdata: 8'h00, exp_rd: 8'h77};
        do_access(wv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer for the shared data memory. It multiplexes single-word read/write requests from the core control FSM and from an external host/debug port onto the memory's single W/ADDR/DATA_WR/DATA_RD port. Each access is sequenced through a small FSM with a registered grant and a registered read response. It sits between the core FSM, the host interface and the DATA_MEM instance.

## Interface
Parameters:
- DATA_SIZE, 8, data word width
- ADDR_SIZE, 4, data memory address width
- RD_LAT, 1, memory read latency in cycles from address to valid DATA_RD; legal range 1..4

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset; one clock; synchronous, active-high
- core_req  in  1  core access request
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_SIZE  core address
- core_wdata  in  DATA_SIZE  core write data
- core_gnt  out  1  one-cycle pulse: core request issued to memory
- core_rvalid  out  1  one-cycle pulse: core_rdata valid
- core_rdata  out  DATA_SIZE  core read data, held until next core read completes
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_SIZE/DATA_SIZE  host request, same meaning as core_*
- host_gnt, host_rvalid, host_rdata  out  1/1/DATA_SIZE  host response, same meaning as core_*
- mem_w  out  1  memory write enable
- mem_addr  out  ADDR_SIZE  memory address
- mem_wdata  out  DATA_SIZE  memory write data
- mem_rdata  in  DATA_SIZE  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req sampled high, pick winner, latch its we/addr/wdata and owner ID, go ISSUE; else stay.
- ISSUE (1 cycle): drive mem_addr/mem_wdata from latch; mem_w = latched we; winner's gnt = 1. Write → IDLE. Read → WAIT, latency counter loaded with RD_LAT.
- WAIT (RD_LAT cycles): mem_addr held, mem_w = 0. On the last WAIT cycle's edge, mem_rdata is captured into the owner's rdata register; owner's rvalid = 1 the following cycle; state → IDLE.
- Arbitration (default): host has fixed priority over core; core waits while host_req is held.
- Requests are sampled only in IDLE. A requester must hold req and fields until its gnt. A req still high in the IDLE cycle after gnt is a new request.
- The non-owner's rdata is never modified. The rdata registers of both ports persist across accesses.
- Reset: state IDLE; all gnt, rvalid, mem_w, busy = 0; mem_addr, mem_wdata, core_rdata, host_rdata = 0; round-robin pointer = "host last".

## Timing
- Write: req high in cycle 0 (IDLE) → cycle 1 gnt = 1, mem_w = 1 → cycle 2 IDLE, next arbitration possible. Peak throughput is 1 write per 2 cycles.
- Read: req in cycle 0 → gnt in cycle 1 (ISSUE) → WAIT in cycles 2..1+RD_LAT → rvalid in cycle 2+RD_LAT, which is also an IDLE arbitration cycle.
- mem_w is high only in ISSUE of a write. It is never high in IDLE or WAIT.
- gnt and rvalid of both ports are never high simultaneously for the same port. rvalid of one port may coincide with IDLE sampling of the other port.
- rst high in any cycle aborts the in-flight access: no gnt/rvalid issued afterwards, mem_w = 0 from the next cycle, latched request discarded.
- Simultaneous core_req and host_req in IDLE: resolved by the arbitration rule, loser waits at least until the next IDLE.

## Configuration
- DATA_MEM_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests, grant the port not granted last. The pointer updates on each ISSUE. After reset, core wins the first tie. A single requester is always granted regardless of pointer.
- Not defined: fixed host priority as in Operation; no pointer register.

## Test plan
- Reset, then core write addr 0x3 data 0xA5 → core_gnt at cycle 1 with mem_w = 1, mem_addr = 0x3, mem_wdata = 0xA5; busy low at cycle 2.
- Host read addr 0x3 with RD_LAT = 2, memory returning 0xA5 → host_gnt at cycle 1; host_rvalid = 1 and host_rdata = 0xA5 at cycle 4; core_rdata unchanged.
- Both req held continuously, writes, macro undefined → host granted every ISSUE, core_gnt never asserts. With DATA_MEM_ARB_RR_EN defined → grants alternate core, host, core, host.
- Back-to-back core reads 0x1, 0x2 (RD_LAT = 1, data 0x11, 0x22) → rvalid at cycles 3 and 6 with 0x11, 0x22; second gnt at cycle 4.
- rst asserted during WAIT of a host read → no host_rvalid, mem_w = 0, all outputs at reset values next cycle; subsequent core write completes normally.
